mips_multicycle_ctrl: RTL and testbench

Moore-style control FSM for the multicycle MIPS datapath, sitting directly upstream of the alu block. It decodes op/funct from the instruction register, sequences each instruction through fetch/decode/execute/memory/writeback steps, and drives every datapath enable plus the 3-bit alucont consumed by the ALU. It also keeps a retired-instruction counter for bring-up and debug.

---
 rtl/mips_multicycle_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath enables and the ALU op code, and counts retired instructions.
module mips_multicycle_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  output logic                 memwrite,
  output logic                 iord,
  output logic                 irwrite,
  output logic                 regdst,
  output logic                 memtoreg,
  output logic                 regwrite,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic [1:0]           pcsrc,
  output logic                 pcen,
  output logic [2:0]           alucont,
  output logic [CNT_WIDTH-1:0] instret
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   instret_q, instret_d;
  logic                   retire;
  logic                   funct_legal;

  logic       memwrite_q, memwrite_d;
  logic       iord_q, iord_d;
  logic       irwrite_q, irwrite_d;
  logic       regdst_q, regdst_d;
  logic       memtoreg_q, memtoreg_d;
  logic       regwrite_q, regwrite_d;
  logic       alusrca_q, alusrca_d;
  logic [1:0] alusrcb_q, alusrcb_d;
  logic [1:0] pcsrc_q, pcsrc_d;
  logic       pcwrite_q, pcwrite_d;
  logic       branch_q, branch_d;

  always_comb begin
    funct_legal = 1'b0;
    case (funct)
      6'b100000, 6'b100010, 6'b100100, 6'b101010, 6'b100101: funct_legal = 1'b1;
      default: funct_legal = 1'b0;
    endcase
  end

  // Unreachable encodings fall through to the default arm and recover to FETCH.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   state_d = MEMWB;
      RTYPEEX: state_d = funct_legal ? RTYPEWB : FETCH;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    retire = 1'b0;
    case (state_q)
      MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX: retire = 1'b1;
      default: retire = 1'b0;
    endcase
    instret_d = retire ? instret_q + CNT_WIDTH'(1) : instret_q;
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_comb begin
    memwrite_d = 1'b0;
    iord_d     = 1'b0;
    irwrite_d  = 1'b0;
    regdst_d   = 1'b0;
    memtoreg_d = 1'b0;
    regwrite_d = 1'b0;
    alusrca_d  = 1'b0;
    alusrcb_d  = 2'b00;
    pcsrc_d    = 2'b00;
    pcwrite_d  = 1'b0;
    branch_d   = 1'b0;
    case (state_d)
      FETCH: begin
        alusrcb_d = 2'b01;
        irwrite_d = 1'b1;
        pcwrite_d = 1'b1;
      end
      DECODE:  alusrcb_d = 2'b11;
      MEMADR: begin
        alusrca_d = 1'b1;
        alusrcb_d = 2'b10;
      end
      MEMRD:   iord_d = 1'b1;
      MEMWB: begin
        memtoreg_d = 1'b1;
        regwrite_d = 1'b1;
      end
      MEMWR: begin
        iord_d     = 1'b1;
        memwrite_d = 1'b1;
      end
      RTYPEEX: alusrca_d = 1'b1;
      RTYPEWB: begin
        regdst_d   = 1'b1;
        regwrite_d = 1'b1;
      end
      BEQEX: begin
        alusrca_d = 1'b1;
        pcsrc_d   = 2'b01;
        branch_d  = 1'b1;
      end
      ADDIEX: begin
        alusrca_d = 1'b1;
        alusrcb_d = 2'b10;
      end
      ADDIWB:  regwrite_d = 1'b1;
      JEX: begin
        pcsrc_d   = 2'b10;
        pcwrite_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FETCH;
      instret_q  <= '0;
      memwrite_q <= 1'b0;
      iord_q     <= 1'b0;
      irwrite_q  <= 1'b1;
      regdst_q   <= 1'b0;
      memtoreg_q <= 1'b0;
      regwrite_q <= 1'b0;
      alusrca_q  <= 1'b0;
      alusrcb_q  <= 2'b01;
      pcsrc_q    <= 2'b00;
      pcwrite_q  <= 1'b1;
      branch_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      instret_q  <= instret_d;
      memwrite_q <= memwrite_d;
      iord_q     <= iord_d;
      irwrite_q  <= irwrite_d;
      regdst_q   <= regdst_d;
      memtoreg_q <= memtoreg_d;
      regwrite_q <= regwrite_d;
      alusrca_q  <= alusrca_d;
      alusrcb_q  <= alusrcb_d;
      pcsrc_q    <= pcsrc_d;
      pcwrite_q  <= pcwrite_d;
      branch_q   <= branch_d;
    end
  end

  always_comb begin
    alucont = ALU_ADD;
    if (state_q == BEQEX) begin
      alucont = ALU_SUB;
    end else if (state_q == RTYPEEX) begin
      case (funct)
        6'b100010: alucont = ALU_SUB;
        6'b100100: alucont = ALU_AND;
        6'b101010: alucont = ALU_SLT;
        6'b100101: alucont = ALU_OR;
        default:   alucont = ALU_ADD;
      endcase
    end
  end

  // The FETCH reset image has irwrite/pcwrite set, so write enables are masked while reset is high.
  assign memwrite = memwrite_q & ~reset;
  assign irwrite  = irwrite_q & ~reset;
  assign regwrite = regwrite_q & ~reset;
  assign pcen     = (pcwrite_q | (branch_q & zero)) & ~reset;
  assign iord     = iord_q;
  assign regdst   = regdst_q;
  assign memtoreg = memtoreg_q;
  assign alusrca  = alusrca_q;
  assign alusrcb  = alusrcb_q;
  assign pcsrc    = pcsrc_q;
  assign instret  = instret_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: an instruction-level model queues the
// expected per-cycle outputs and a monitor compares them on the falling edge.
module tb_mips_multicycle_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [5:0]   op = 6'd0;
  logic [5:0]   funct = 6'd0;
  logic         zero = 1'b0;
  logic         memwrite, iord, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
  logic [1:0]   alusrcb, pcsrc;
  logic [2:0]   alucont;
  logic [W-1:0] instret;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.CNT_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memwrite(memwrite), .iord(iord), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .pcen(pcen), .alucont(alucont),
    .instret(instret)
  );

  typedef struct {
    string        name;
    logic [14:0]  vec;
    logic [W-1:0] cnt;
  } exp_t;

  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  int    modelCount = 0;
  int    zeroMode = -1;
  logic [14:0] actVec;

  assign actVec = {memwrite, iord, irwrite, regdst, memtoreg, regwrite,
                   alusrca, alusrcb, pcsrc, pcen, alucont};

  function automatic logic [2:0] aluFor(logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b101010: return 3'b111;
      6'b100101: return 3'b001;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic bit isLegalFunct(logic [5:0] f);
    return f inside {6'b100000, 6'b100010, 6'b100100, 6'b101010, 6'b100101};
  endfunction

  // Expected outputs for one named cycle of an instruction.
  function automatic logic [14:0] expVec(string ph, logic [5:0] f, logic z);
    logic mw, io, ir, rd, mr, rw, as, pe;
    logic [1:0] bs, ps;
    logic [2:0] ac;
    mw = 0; io = 0; ir = 0; rd = 0; mr = 0; rw = 0; as = 0; pe = 0;
    bs = 2'b00; ps = 2'b00; ac = 3'b010;
    case (ph)
      "reset":  bs = 2'b01;
      "fetch":  begin ir = 1; bs = 2'b01; pe = 1; end
      "decode": bs = 2'b11;
      "memadr": begin as = 1; bs = 2'b10; end
      "memrd":  io = 1;
      "memwb":  begin mr = 1; rw = 1; end
      "memwr":  begin io = 1; mw = 1; end
      "rex":    begin as = 1; ac = aluFor(f); end
      "rwb":    begin rd = 1; rw = 1; end
      "beq":    begin as = 1; ps = 2'b01; pe = z; ac = 3'b110; end
      "addiex": begin as = 1; bs = 2'b10; end
      "addiwb": rw = 1;
      "jex":    begin ps = 2'b10; pe = 1; end
      default:  ;
    endcase
    return {mw, io, ir, rd, mr, rw, as, bs, ps, pe, ac};
  endfunction

  task automatic pushExp(string ph, logic [5:0] f);
    exp_t e;
    e.name = ph;
    e.vec  = expVec(ph, f, zero);
    e.cnt  = W'(modelCount);
    sb.push_back(e);
  endtask

  task automatic applyStimulus(string ph, logic [5:0] o, logic [5:0] f);
    @(posedge clk);
    #1;
    reset = 1'b0;
    op    = o;
    funct = f;
    zero  = (zeroMode < 0) ? 1'($urandom_range(0, 1)) : zeroMode[0];
    pushExp(ph, f);
  endtask

  task automatic resetCycle();
    @(posedge clk);
    #2;
    reset = 1'b1;
    modelCount = 0;
    pushExp("reset", funct);
  endtask

  // abortAt = k asserts reset during the k-th cycle of the instruction (0 = none).
  task automatic issueInstr(logic [5:0] o, logic [5:0] f, int abortAt);
    string ph[$];
    bit    retires;
    ph.push_back("fetch");
    ph.push_back("decode");
    retires = 1'b1;
    case (o)
      6'b100011: begin ph.push_back("memadr"); ph.push_back("memrd"); ph.push_back("memwb"); end
      6'b101011: begin ph.push_back("memadr"); ph.push_back("memwr"); end
      6'b000000: begin
        ph.push_back("rex");
        if (isLegalFunct(f)) ph.push_back("rwb");
        else retires = 1'b0;
      end
      6'b000100: ph.push_back("beq");
      6'b001000: begin ph.push_back("addiex"); ph.push_back("addiwb"); end
      6'b000010: ph.push_back("jex");
      default:   retires = 1'b0;
    endcase
    foreach (ph[i]) begin
      if (abortAt != 0 && i + 1 == abortAt) begin
        resetCycle();
        return;
      end
      applyStimulus(ph[i], o, f);
    end
    if (retires) modelCount = (modelCount + 1) % (1 << W);
  endtask

  task automatic checkOutput();
    exp_t e;
    e = sb.pop_front();
    checks++;
    if (actVec !== e.vec) begin
      errors++;
      $display("[TB] FAIL %s outputs: actual %b required %b (mw,iord,irw,rdst,m2r,rw,asa,asb,pcs,pcen,alu)",
               e.name, actVec, e.vec);
    end
    checks++;
    if (instret !== e.cnt) begin
      errors++;
      $display("[TB] FAIL %s instret: actual %0d required %0d", e.name, instret, e.cnt);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) checkOutput();
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int sel;
    logic [5:0] o, f;
    resetCycle();
    resetCycle();
    issueInstr(6'b100011, 6'($urandom), 0);
    issueInstr(6'b000000, 6'b100010, 0);
    issueInstr(6'b000000, 6'b101010, 0);
    issueInstr(6'b000000, 6'b100101, 0);
    zeroMode = 1;
    issueInstr(6'b000100, 6'($urandom), 0);
    zeroMode = 0;
    issueInstr(6'b000100, 6'($urandom), 0);
    zeroMode = -1;
    issueInstr(6'b111111, 6'($urandom), 0);
    issueInstr(6'b000000, 6'b000111, 0);
    issueInstr(6'b101011, 6'($urandom), 0);
    issueInstr(6'b001000, 6'($urandom), 0);
    issueInstr(6'b100011, 6'($urandom), 4);
    resetCycle();
    for (int i = 0; i < 16; i++) issueInstr(6'b000010, 6'($urandom), 0);
    issueInstr(6'b100011, 6'($urandom), 0);
    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 7);
      f   = 6'($urandom);
      case (sel)
        0: o = 6'b100011;
        1: o = 6'b101011;
        2: begin o = 6'b000000; f = {3'b100, 3'($urandom_range(0, 4))}; end
        3: o = 6'b000000;
        4: o = 6'b000100;
        5: o = 6'b001000;
        6: o = 6'b000010;
        default: o = 6'($urandom);
      endcase
      issueInstr(o, f, ($urandom_range(0, 19) == 0) ? $urandom_range(1, 3) : 0);
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard drain: actual %0d pending required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
